// File: rtl/cr_clic_arb_seq_if.sv
// Handshake bundle between the CLIC kid slices, the arbitration sequencer and the E902 core.
interface cr_clic_arb_seq_if #(
    parameter int unsigned NUM_INT = 32,
    parameter int unsigned ID_W    = 5,
    parameter int unsigned PRIO_W  = 3
);
    logic [NUM_INT-1:0]        kid_arb_int_req;
    logic [NUM_INT*PRIO_W-1:0] kid_arb_prio;
    logic                      cpu_clic_mie;
    logic [PRIO_W:0]           cpu_clic_thresh;
    logic                      cpu_clic_int_ack;
    logic                      clic_cpu_int_vld;
    logic [ID_W-1:0]           clic_cpu_int_id;
    logic [PRIO_W-1:0]         clic_cpu_int_prio;
    logic                      arb_kid_claim_vld;
    logic [ID_W-1:0]           arb_kid_claim_id;
    logic                      arb_busy;

    modport slave (
        input  kid_arb_int_req, kid_arb_prio, cpu_clic_mie, cpu_clic_thresh, cpu_clic_int_ack,
        output clic_cpu_int_vld, clic_cpu_int_id, clic_cpu_int_prio,
               arb_kid_claim_vld, arb_kid_claim_id, arb_busy
    );

    modport master (
        output kid_arb_int_req, kid_arb_prio, cpu_clic_mie, cpu_clic_thresh, cpu_clic_int_ack,
        input  clic_cpu_int_vld, clic_cpu_int_id, clic_cpu_int_prio,
               arb_kid_claim_vld, arb_kid_claim_id, arb_busy
    );
endinterface

// File: rtl/cr_clic_arb_seq.sv
// CLIC arbitration sequencer: 2-stage registered priority tree, offer/ack handshake, claim pulse.
// Optional round-robin tie-break on equal priority: define CLIC_ARB_RR_TIE_EN.
module cr_clic_arb_seq #(
    parameter int unsigned NUM_INT = 32,
    parameter int unsigned ID_W    = 5,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic                cpuclk,
    input  logic                cpurst,
    cr_clic_arb_seq_if.slave    bus
);
    localparam int unsigned NGRP = NUM_INT / 8;

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, CLAIM} state_e;

    state_e                        state_q, state_d;
    logic [NGRP-1:0]               s1_vld_q, s1_vld_d;
    logic [NGRP-1:0][ID_W-1:0]     s1_id_q, s1_id_d;
    logic [NGRP-1:0][PRIO_W-1:0]   s1_prio_q, s1_prio_d;
    logic                          s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]               s2_id_q, s2_id_d;
    logic [PRIO_W-1:0]             s2_prio_q, s2_prio_d;
    logic [ID_W-1:0]               off_id_q, off_id_d;
    logic [PRIO_W-1:0]             off_prio_q, off_prio_d;
    logic [ID_W-1:0]               claim_id_q, claim_id_d;
    logic [1:0]                    blank_q, blank_d;
    logic                          flush, s2_elig, off_elig;
`ifdef CLIC_ARB_RR_TIE_EN
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
`endif

    // Candidate c beats incumbent w: higher prio, then tie-break on id.
    function automatic logic beats(input logic [PRIO_W-1:0] cp, input logic [ID_W-1:0] cid,
                                   input logic [PRIO_W-1:0] wp, input logic [ID_W-1:0] wid);
`ifdef CLIC_ARB_RR_TIE_EN
        logic ca, wa;
        ca = cid > rr_ptr_q;
        wa = wid > rr_ptr_q;
        return (cp > wp) || ((cp == wp) && ({ca, ~cid} > {wa, ~wid}));
`else
        return (cp > wp) || ((cp == wp) && (cid < wid));
`endif
    endfunction

    // Level n+1 means running at prio n, so prio p only interrupts when p+1 exceeds it.
    function automatic logic above_lvl(input logic [PRIO_W-1:0] p, input logic [PRIO_W:0] thr);
        return ({1'b0, p} + (PRIO_W+1)'(1)) > thr;
    endfunction

    assign flush = (state_q == CLAIM);

    always_comb begin : p_stage1
        logic [ID_W-1:0]   cid;
        logic [PRIO_W-1:0] cp;
        cid       = '0;
        cp        = '0;
        s1_vld_d  = '0;
        s1_id_d   = '0;
        s1_prio_d = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                cid = ID_W'(g*8 + k);
                cp  = bus.kid_arb_prio[(g*8 + k)*PRIO_W +: PRIO_W];
                if (bus.kid_arb_int_req[g*8 + k] &&
                    (!s1_vld_d[g] || beats(cp, cid, s1_prio_d[g], s1_id_d[g]))) begin
                    s1_vld_d[g]  = 1'b1;
                    s1_id_d[g]   = cid;
                    s1_prio_d[g] = cp;
                end
            end
        end
        if (flush) s1_vld_d = '0;
    end

    always_comb begin : p_stage2
        s2_vld_d  = 1'b0;
        s2_id_d   = '0;
        s2_prio_d = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            if (s1_vld_q[g] && (!s2_vld_d || beats(s1_prio_q[g], s1_id_q[g], s2_prio_d, s2_id_d))) begin
                s2_vld_d  = 1'b1;
                s2_id_d   = s1_id_q[g];
                s2_prio_d = s1_prio_q[g];
            end
        end
        if (flush) s2_vld_d = 1'b0;
    end

    // The live req bit is re-checked so a winner that already dropped out of the pipe is never offered.
    assign s2_elig  = s2_vld_q && (blank_q == '0) && bus.kid_arb_int_req[s2_id_q] &&
                      bus.cpu_clic_mie && above_lvl(s2_prio_q, bus.cpu_clic_thresh);
    assign off_elig = bus.kid_arb_int_req[off_id_q] && bus.cpu_clic_mie &&
                      above_lvl(off_prio_q, bus.cpu_clic_thresh);

    always_comb begin
        state_d    = state_q;
        off_id_d   = off_id_q;
        off_prio_d = off_prio_q;
        claim_id_d = claim_id_q;
        blank_d    = (blank_q != '0) ? blank_q - 2'd1 : '0;
`ifdef CLIC_ARB_RR_TIE_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: if (|bus.kid_arb_int_req) state_d = SCAN;
            SCAN: begin
                if (s2_elig) begin
                    state_d    = OFFER;
                    off_id_d   = s2_id_q;
                    off_prio_d = s2_prio_q;
                end else if (!s2_vld_q && !(|bus.kid_arb_int_req)) begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (bus.cpu_clic_int_ack) begin
                    state_d    = CLAIM;
                    claim_id_d = off_id_q;
`ifdef CLIC_ARB_RR_TIE_EN
                    rr_ptr_d   = off_id_q;
`endif
                end else if (!off_elig) begin
                    state_d = SCAN;
                end else if (s2_elig && (s2_prio_q > off_prio_q)) begin
                    off_id_d   = s2_id_q;
                    off_prio_d = s2_prio_q;
                end
            end
            CLAIM: begin
                state_d = SCAN;
                blank_d = 2'd2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= IDLE;
            s1_vld_q   <= '0;
            s1_id_q    <= '0;
            s1_prio_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_id_q    <= '0;
            s2_prio_q  <= '0;
            off_id_q   <= '0;
            off_prio_q <= '0;
            claim_id_q <= '0;
            blank_q    <= '0;
`ifdef CLIC_ARB_RR_TIE_EN
            rr_ptr_q   <= ID_W'(NUM_INT - 1);
`endif
        end else begin
            state_q    <= state_d;
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            s1_prio_q  <= s1_prio_d;
            s2_vld_q   <= s2_vld_d;
            s2_id_q    <= s2_id_d;
            s2_prio_q  <= s2_prio_d;
            off_id_q   <= off_id_d;
            off_prio_q <= off_prio_d;
            claim_id_q <= claim_id_d;
            blank_q    <= blank_d;
`ifdef CLIC_ARB_RR_TIE_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign bus.clic_cpu_int_vld  = (state_q == OFFER);
    assign bus.clic_cpu_int_id   = off_id_q;
    assign bus.clic_cpu_int_prio = off_prio_q;
    assign bus.arb_kid_claim_vld = (state_q == CLAIM);
    assign bus.arb_kid_claim_id  = claim_id_q;
    assign bus.arb_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cr_clic_arb_seq.sv
// Directed + randomized bench for cr_clic_arb_seq against an argmax reference of the arbitration rules.
module tb_cr_clic_arb_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] req = '0;
    int   pr[32];
    int   rr = 31;

    cr_clic_arb_seq_if #(.NUM_INT(32), .ID_W(5), .PRIO_W(3)) bus ();

    cr_clic_arb_seq #(.NUM_INT(32), .ID_W(5), .PRIO_W(3)) u_dut (
        .cpuclk (clk),
        .cpurst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        logic [95:0] pv;
        pv = '0;
        for (int i = 0; i < 32; i++) pv[i*3 +: 3] = 3'(pr[i]);
        bus.kid_arb_int_req = req;
        bus.kid_arb_prio    = pv;
    endtask

    task automatic wait_vld(input string tag, input int maxc, output int cyc);
        cyc = 0;
        while (bus.clic_cpu_int_vld !== 1'b1 && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk(tag, bus.clic_cpu_int_vld, 1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (bus.arb_busy !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("idle", bus.arb_busy, 0);
    endtask

    // Ack the current offer, expect a one-cycle claim for id; optionally clear its pending bit.
    task automatic do_ack(input string tag, input int id, input bit clr);
        bus.cpu_clic_int_ack = 1'b1;
        tick();
        bus.cpu_clic_int_ack = 1'b0;
        chk({tag, "_claim"}, bus.arb_kid_claim_vld, 1);
        chk({tag, "_claim_id"}, bus.arb_kid_claim_id, id);
        chk({tag, "_vld_off"}, bus.clic_cpu_int_vld, 0);
        rr = id;
        if (clr) begin
            req[id] = 1'b0;
            apply();
        end
        tick();
        chk({tag, "_claim_1cyc"}, bus.arb_kid_claim_vld, 0);
    endtask

    // Best pending id by score prio*64 (+32 if after rr pointer) + (31-id); -1 if none.
    function automatic int ref_win(input logic [31:0] r, input int rrp);
        int best, bs, s;
        best = -1;
        bs   = -1;
        for (int i = 0; i < 32; i++) begin
            if (r[i]) begin
                s = pr[i]*64 + (31 - i);
`ifdef CLIC_ARB_RR_TIE_EN
                if (i > rrp) s += 32;
`endif
                if (s > bs) begin
                    bs   = s;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    initial begin
        int cyc, w, n, idx, thr;
        bit mie, expv;
        int exp5[3];
        for (int i = 0; i < 32; i++) pr[i] = 0;
        bus.cpu_clic_mie     = 1'b1;
        bus.cpu_clic_thresh  = '0;
        bus.cpu_clic_int_ack = 1'b0;
        apply();
        tick();
        tick();
        chk("rst_vld", bus.clic_cpu_int_vld, 0);
        chk("rst_id", bus.clic_cpu_int_id, 0);
        chk("rst_prio", bus.clic_cpu_int_prio, 0);
        chk("rst_claim", bus.arb_kid_claim_vld, 0);
        chk("rst_claim_id", bus.arb_kid_claim_id, 0);
        chk("rst_busy", bus.arb_busy, 0);

        // T1: exact 3-edge latency from IDLE
        rst = 1'b0;
        req[5] = 1'b1; pr[5] = 3; apply();
        tick(); chk("t1_e1", bus.clic_cpu_int_vld, 0);
        tick(); chk("t1_e2", bus.clic_cpu_int_vld, 0);
        tick(); chk("t1_e3", bus.clic_cpu_int_vld, 1);
        chk("t1_id", bus.clic_cpu_int_id, 5);
        chk("t1_prio", bus.clic_cpu_int_prio, 3);
        do_ack("t1", 5, 1);

        // T2: higher prio wins; next offer at least 4 cycles after ack
        wait_idle();
        req[2] = 1'b1; pr[2] = 4; req[9] = 1'b1; pr[9] = 6; apply();
        wait_vld("t2_vld", 12, cyc);
        chk("t2_id", bus.clic_cpu_int_id, 9);
        chk("t2_prio", bus.clic_cpu_int_prio, 6);
        bus.cpu_clic_int_ack = 1'b1;
        tick();
        bus.cpu_clic_int_ack = 1'b0;
        chk("t2_claim_id", bus.arb_kid_claim_id, 9);
        req[9] = 1'b0; apply();
        tick();
        chk("t2_claim_1cyc", bus.arb_kid_claim_vld, 0);
        wait_vld("t2_revld", 12, cyc);
        chk("t2_gap_ge4", (cyc + 1) >= 4, 1);
        chk("t2_id2", bus.clic_cpu_int_id, 2);
        chk("t2_prio2", bus.clic_cpu_int_prio, 4);
        do_ack("t2b", 2, 1);

        // T3: preempt while offering
        wait_idle();
        req[4] = 1'b1; pr[4] = 2; apply();
        wait_vld("t3_vld", 12, cyc);
        chk("t3_id4", bus.clic_cpu_int_id, 4);
        req[20] = 1'b1; pr[20] = 7; apply();
        for (int c = 0; c < 6 && bus.clic_cpu_int_id !== 5'd20; c++) begin
            tick();
            chk("t3_vld_hold", bus.clic_cpu_int_vld, 1);
        end
        chk("t3_id20", bus.clic_cpu_int_id, 20);
        chk("t3_prio7", bus.clic_cpu_int_prio, 7);
        do_ack("t3", 20, 1);
        wait_vld("t3_reoffer", 12, cyc);
        chk("t3_id4b", bus.clic_cpu_int_id, 4);

        // T4: level rises to the offered prio -> withdraw; ack while vld=0 ignored
        bus.cpu_clic_thresh = 4'd3;
        tick();
        chk("t4_withdraw", bus.clic_cpu_int_vld, 0);
        bus.cpu_clic_int_ack = 1'b1;
        tick();
        tick();
        chk("t4_no_claim", bus.arb_kid_claim_vld, 0);
        chk("t4_still_off", bus.clic_cpu_int_vld, 0);
        bus.cpu_clic_int_ack = 1'b0;
        bus.cpu_clic_thresh = '0;
        wait_vld("t4_reoffer", 6, cyc);
        chk("t4_id4", bus.clic_cpu_int_id, 4);

        // T6: async reset mid-offer with ack high
        bus.cpu_clic_int_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("t6_vld_async", bus.clic_cpu_int_vld, 0);
        chk("t6_claim_async", bus.arb_kid_claim_vld, 0);
        tick();
        rst = 1'b0;
        bus.cpu_clic_int_ack = 1'b0;
        rr = 31;
        tick(); chk("t6_e1_vld", bus.clic_cpu_int_vld, 0); chk("t6_e1_claim", bus.arb_kid_claim_vld, 0);
        tick(); chk("t6_e2_vld", bus.clic_cpu_int_vld, 0); chk("t6_e2_claim", bus.arb_kid_claim_vld, 0);
        tick(); chk("t6_e3_vld", bus.clic_cpu_int_vld, 1); chk("t6_id", bus.clic_cpu_int_id, 4);
        req = '0; apply();
        tick();
        chk("t6_drop", bus.clic_cpu_int_vld, 0);
        wait_idle();

        // T5: equal-prio tie handling over three level-kept claims
`ifdef CLIC_ARB_RR_TIE_EN
        exp5 = '{1, 3, 8};
`else
        exp5 = '{1, 1, 1};
`endif
        req[1] = 1'b1; req[3] = 1'b1; req[8] = 1'b1;
        pr[1] = 5; pr[3] = 5; pr[8] = 5; apply();
        for (int k = 0; k < 3; k++) begin
            wait_vld("t5_vld", 12, cyc);
            chk("t5_id", bus.clic_cpu_int_id, exp5[k]);
            do_ack("t5", exp5[k], 0);
        end
        req = '0; apply();
        wait_idle();

        // Random rounds from IDLE against the reference model
        for (int r = 0; r < 40; r++) begin
            wait_idle();
            req = '0;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                idx = $urandom_range(0, 31);
                req[idx] = 1'b1;
                pr[idx] = $urandom_range(0, 7);
            end
            mie = ($urandom_range(0, 9) != 0);
            thr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            bus.cpu_clic_mie    = mie;
            bus.cpu_clic_thresh = 4'(thr);
            apply();
            w = ref_win(req, rr);
            expv = (w >= 0) && mie && (pr[w] + 1 > thr);
            tick(); chk("rnd_e1", bus.clic_cpu_int_vld, 0);
            tick(); chk("rnd_e2", bus.clic_cpu_int_vld, 0);
            tick(); chk("rnd_e3", bus.clic_cpu_int_vld, expv);
            if (expv) begin
                chk("rnd_id", bus.clic_cpu_int_id, w);
                chk("rnd_prio", bus.clic_cpu_int_prio, pr[w]);
                do_ack("rnd", w, $urandom_range(0, 1) == 1);
            end else begin
                repeat (3) tick();
                chk("rnd_none", bus.clic_cpu_int_vld, 0);
            end
            req = '0; apply();
            bus.cpu_clic_mie    = 1'b1;
            bus.cpu_clic_thresh = '0;
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
